// File: rtl/i2c_read_capture.sv
// Passive I2C read-burst monitor: watches SCL/SDA, decodes the address byte and
// captures the bytes a slave returns to the master as strobes plus a held frame.
module i2c_read_capture #(
  parameter logic [6:0] DEV_ADDR    = 7'h50,
  parameter int         NBYTES      = 7,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scl,
  input  logic                    sda_in,
  output logic [7:0]              data_out,
  output logic                    data_valid,
  output logic [$clog2(NBYTES):0] byte_idx,
  output logic [8*NBYTES-1:0]     frame,
  output logic                    frame_done,
  output logic                    frame_err
);

  localparam int CW = $clog2(NBYTES) + 1;
  localparam logic [CW-1:0] NB_LAST = CW'(NBYTES);
  localparam logic [CW-1:0] NB_OVER = CW'(NBYTES + 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WAIT_START,
    DATA,
    DATA_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_reg;
  logic [SYNC_STAGES-1:0] sda_sync_reg;
  logic                   scl_prev_reg;
  logic                   sda_prev_reg;
  logic                   scl_s;
  logic                   sda_s;
  logic                   scl_rise;
  logic                   start_det;
  logic                   stop_det;
  logic                   in_burst;
  logic                   byte_done;
  logic [7:0]             byte_new;

  state_t                 state_reg;
  logic [3:0]             bit_cnt_reg;
  logic [7:0]             shift_reg;
  logic [CW-1:0]          count_reg;
  logic [7:0]             shadow_reg [NBYTES];
  logic [8*NBYTES-1:0]    shadow_flat;

  // Synchronisers preset high so a reset looks like an idle bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_reg <= '1;
      sda_sync_reg <= '1;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
    end else begin
      scl_sync_reg <= {scl_sync_reg[SYNC_STAGES-2:0], scl};
      sda_sync_reg <= {sda_sync_reg[SYNC_STAGES-2:0], sda_in};
      scl_prev_reg <= scl_sync_reg[SYNC_STAGES-1];
      sda_prev_reg <= sda_sync_reg[SYNC_STAGES-1];
    end
  end

  assign scl_s     = scl_sync_reg[SYNC_STAGES-1];
  assign sda_s     = sda_sync_reg[SYNC_STAGES-1];
  assign scl_rise  = scl_s && !scl_prev_reg;
  assign start_det = scl_s && sda_prev_reg && !sda_s;
  assign stop_det  = scl_s && !sda_prev_reg && sda_s;
  assign in_burst  = (state_reg == DATA) || (state_reg == DATA_ACK);
  assign byte_new  = {shift_reg[6:0], sda_s};
  assign byte_done = scl_rise && !start_det && !stop_det &&
                     (state_reg == DATA) && (bit_cnt_reg == 4'd7);

  // Shadow holds the burst in progress; frame only sees it on a clean finish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NBYTES; i++) shadow_reg[i] <= '0;
    end else if (byte_done) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (count_reg == CW'(i)) shadow_reg[i] <= byte_new;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_pack
      assign shadow_flat[8*(NBYTES-gi)-1 -: 8] = shadow_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      count_reg   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      byte_idx    <= '0;
      frame       <= '0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      if (start_det) begin
        frame_err   <= in_burst;
        state_reg   <= ADDR;
        bit_cnt_reg <= '0;
      end else if (stop_det) begin
        frame_err   <= in_burst;
        state_reg   <= IDLE;
        bit_cnt_reg <= '0;
      end else if (scl_rise) begin
        case (state_reg)
          ADDR: begin
            shift_reg   <= byte_new;
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) state_reg <= ADDR_ACK;
          end
          ADDR_ACK: begin
            bit_cnt_reg <= '0;
            if (shift_reg[7:1] != DEV_ADDR || !shift_reg[0]) begin
              state_reg <= WAIT_START;
            end else if (!sda_s) begin
              state_reg <= DATA;
              count_reg <= '0;
            end else begin
              frame_err <= 1'b1;
              state_reg <= IDLE;
            end
          end
          DATA: begin
            shift_reg   <= byte_new;
            bit_cnt_reg <= bit_cnt_reg + 4'd1;
            if (bit_cnt_reg == 4'd7) begin
              data_out   <= byte_new;
              data_valid <= 1'b1;
              byte_idx   <= (count_reg < NB_LAST) ? count_reg : NB_LAST;
              if (count_reg != NB_OVER) count_reg <= count_reg + 1'b1;
              state_reg  <= DATA_ACK;
            end
          end
          DATA_ACK: begin
            bit_cnt_reg <= '0;
            if (!sda_s) begin
              // An ACK after the byte past the last one means the master overran.
              if (count_reg == NB_OVER) begin
                frame_err <= 1'b1;
                state_reg <= WAIT_START;
              end else begin
                state_reg <= DATA;
              end
            end else if (count_reg == NB_LAST) begin
              frame      <= shadow_flat;
              frame_done <= 1'b1;
              state_reg  <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state_reg <= IDLE;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_read_capture.sv
// Bench for i2c_read_capture: drives I2C bus traffic and checks strobes and frame
// against a transaction-level model of the read-burst rules.
module tb_i2c_read_capture;

  localparam int N = 7;
  localparam int H = 6;
  localparam int Q = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               scl_b;
  logic               sda_b;
  logic [7:0]         data_out;
  logic               data_valid;
  logic [$clog2(N):0] byte_idx;
  logic [8*N-1:0]     frame;
  logic               frame_done;
  logic               frame_err;

  always #10 clk = ~clk;

  i2c_read_capture #(.DEV_ADDR(7'h50), .NBYTES(N), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl        (scl_b),
    .sda_in     (sda_b),
    .data_out   (data_out),
    .data_valid (data_valid),
    .byte_idx   (byte_idx),
    .frame      (frame),
    .frame_done (frame_done),
    .frame_err  (frame_err)
  );

  // kind: 0 = data byte, 1 = frame done, 2 = frame error
  typedef struct {
    int             kind;
    logic [7:0]     data;
    int             idx;
    logic [8*N-1:0] frm;
  } ev_t;

  ev_t            exp_q[$];
  int             pass_cnt = 0;
  int             total_cnt = 0;
  int             dv_cnt = 0;
  int             fd_cnt = 0;
  int             fe_cnt = 0;
  bit             m_in_data;
  int             m_cnt;
  logic [7:0]     m_shadow [N];
  logic [8*N-1:0] m_frame;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- model ----------------
  function automatic void push(int k, logic [7:0] d, int idx);
    ev_t e;
    e.kind = k;
    e.data = d;
    e.idx  = idx;
    e.frm  = m_frame;
    exp_q.push_back(e);
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_in_data = 1'b0;
    m_cnt     = 0;
    m_frame   = '0;
  endfunction

  function automatic void model_start_stop();
    if (m_in_data) push(2, 8'h00, 0);
    m_in_data = 1'b0;
  endfunction

  function automatic void model_addr(logic [7:0] b, logic a);
    m_in_data = 1'b0;
    if (b[7:1] == 7'h50 && b[0]) begin
      if (!a) begin
        m_in_data = 1'b1;
        m_cnt     = 0;
      end else begin
        push(2, 8'h00, 0);
      end
    end
  endfunction

  function automatic void model_byte(logic [7:0] b);
    if (!m_in_data) return;
    push(0, b, (m_cnt < N) ? m_cnt : N);
    if (m_cnt < N) m_shadow[m_cnt] = b;
    m_cnt++;
  endfunction

  function automatic void model_ack(logic a);
    if (!m_in_data) return;
    if (!a) begin
      if (m_cnt > N) begin
        push(2, 8'h00, 0);
        m_in_data = 1'b0;
      end
    end else begin
      if (m_cnt == N) begin
        m_frame = '0;
        for (int i = 0; i < N; i++) m_frame = {m_frame[8*N-9:0], m_shadow[i]};
        push(1, 8'h00, 0);
      end else begin
        push(2, 8'h00, 0);
      end
      m_in_data = 1'b0;
    end
  endfunction

  // ---------------- compare process ----------------
  initial begin
    int  n;
    int  k;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        n = int'(data_valid) + int'(frame_done) + int'(frame_err);
        if (n > 0) begin
          chk("one_strobe", 64'(n), 64'd1);
          k = data_valid ? 0 : (frame_done ? 1 : 2);
          if (data_valid) dv_cnt++;
          if (frame_done) fd_cnt++;
          if (frame_err)  fe_cnt++;
          if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_strobe: got kind %0d expected none", k);
          end else begin
            e = exp_q.pop_front();
            chk("strobe_kind", 64'(k), 64'(e.kind));
            if (k == 0 && e.kind == 0) begin
              chk("data_out", 64'(data_out), 64'(e.data));
              chk("byte_idx", 64'(byte_idx), 64'(e.idx));
            end
            chk("frame", 64'(frame), 64'(e.frm));
          end
        end
      end
    end
  end

  // ---------------- bus driver ----------------
  task automatic wait_clk(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bus_bit(logic b);
    scl_b = 1'b0;
    wait_clk(Q);
    sda_b = b;
    wait_clk(H);
    scl_b = 1'b1;
    wait_clk(H);
  endtask

  task automatic tx_start();
    model_start_stop();
    scl_b = 1'b0;
    wait_clk(Q);
    sda_b = 1'b1;
    wait_clk(H);
    scl_b = 1'b1;
    wait_clk(H);
    sda_b = 1'b0;
    wait_clk(H);
  endtask

  task automatic tx_stop();
    model_start_stop();
    scl_b = 1'b0;
    wait_clk(Q);
    sda_b = 1'b0;
    wait_clk(H);
    scl_b = 1'b1;
    wait_clk(H);
    sda_b = 1'b1;
    wait_clk(H);
  endtask

  task automatic send_byte(logic [7:0] b, logic a);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    bus_bit(a);
  endtask

  task automatic tx_addr(logic [7:0] b, logic a);
    model_addr(b, a);
    send_byte(b, a);
  endtask

  task automatic tx_data(logic [7:0] b, logic a);
    model_byte(b);
    model_ack(a);
    send_byte(b, a);
  endtask

  task automatic clr_counts();
    dv_cnt = 0;
    fd_cnt = 0;
    fe_cnt = 0;
  endtask

  task automatic drain();
    wait_clk(30);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    chk("frame_hold", 64'(frame), 64'(m_frame));
  endtask

  task automatic good_burst(bit with_write);
    if (with_write) begin
      tx_start();
      tx_addr(8'hA0, 1'b0);
      tx_data(8'($urandom_range(0, 255)), 1'b0);
    end
    tx_start();
    tx_addr(8'hA1, 1'b0);
    for (int i = 0; i < N; i++) tx_data(8'($urandom_range(0, 255)), (i == N - 1));
    tx_stop();
  endtask

  task automatic abort_burst(int j, int b, bit use_start);
    logic [7:0] x;
    tx_start();
    tx_addr(8'hA1, 1'b0);
    for (int i = 0; i < j; i++) tx_data(8'($urandom_range(0, 255)), 1'b0);
    x = 8'($urandom_range(0, 255));
    if (b == 8) model_byte(x);
    for (int k = 0; k < b; k++) bus_bit(x[7-k]);
    if (use_start) begin
      tx_start();
      tx_addr(8'hA3, 1'b0);
    end
    tx_stop();
  endtask

  task automatic run_bytes(int nb, logic last_ack);
    tx_start();
    tx_addr(8'hA1, 1'b0);
    for (int i = 0; i < nb; i++) tx_data(8'($urandom_range(0, 255)), (i == nb - 1) ? last_ack : 1'b0);
    tx_stop();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] a;
    rst_n = 1'b0;
    scl_b = 1'b1;
    sda_b = 1'b1;
    model_reset();
    wait_clk(3);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_data_valid", 64'(data_valid), 64'd0);
    chk("rst_byte_idx", 64'(byte_idx), 64'd0);
    chk("rst_frame", 64'(frame), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_frame_err", 64'(frame_err), 64'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write phase, repeated START, read of 11..77
    clr_counts();
    tx_start();
    tx_addr(8'hA0, 1'b0);
    tx_data(8'h00, 1'b0);
    tx_start();
    tx_addr(8'hA1, 1'b0);
    for (int i = 0; i < N; i++) tx_data(8'(17 * (i + 1)), (i == N - 1));
    tx_stop();
    drain();
    chk("t1_frame", 64'(frame), 64'h0011223344556677);
    chk("t1_dv", 64'(dv_cnt), 64'd7);
    chk("t1_fd", 64'(fd_cnt), 64'd1);
    chk("t1_fe", 64'(fe_cnt), 64'd0);

    // Mismatched address
    clr_counts();
    tx_start();
    tx_addr(8'hA3, 1'b0);
    for (int i = 0; i < N; i++) tx_data(8'($urandom_range(0, 255)), (i == N - 1));
    tx_stop();
    drain();
    chk("t2_dv", 64'(dv_cnt), 64'd0);
    chk("t2_fd", 64'(fd_cnt), 64'd0);
    chk("t2_frame", 64'(frame), 64'h0011223344556677);

    // Early NACK after 4th byte, then a good burst
    clr_counts();
    run_bytes(4, 1'b1);
    drain();
    chk("t3_dv", 64'(dv_cnt), 64'd4);
    chk("t3_fe", 64'(fe_cnt), 64'd1);
    chk("t3_frame", 64'(frame), 64'h0011223344556677);
    clr_counts();
    good_burst(1'b0);
    drain();
    chk("t3_next_fd", 64'(fd_cnt), 64'd1);

    // STOP after bit 5 of byte 3
    clr_counts();
    abort_burst(2, 5, 1'b0);
    drain();
    chk("t4_dv", 64'(dv_cnt), 64'd2);
    chk("t4_fe", 64'(fe_cnt), 64'd1);
    clr_counts();
    good_burst(1'b1);
    drain();
    chk("t4_next_fd", 64'(fd_cnt), 64'd1);

    // Address NACKed by slave
    clr_counts();
    tx_start();
    tx_addr(8'hA1, 1'b1);
    tx_stop();
    drain();
    chk("t5_fe", 64'(fe_cnt), 64'd1);
    chk("t5_dv", 64'(dv_cnt), 64'd0);

    // Reset in the middle of byte 2
    clr_counts();
    tx_start();
    tx_addr(8'hA1, 1'b0);
    tx_data(8'hC3, 1'b0);
    for (int k = 0; k < 4; k++) bus_bit(1'b1);
    scl_b = 1'b0;
    wait_clk(1);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_data_out", 64'(data_out), 64'd0);
    chk("mid_rst_byte_idx", 64'(byte_idx), 64'd0);
    chk("mid_rst_frame", 64'(frame), 64'd0);
    chk("mid_rst_dv", 64'(data_valid), 64'd0);
    chk("mid_rst_fd", 64'(frame_done), 64'd0);
    chk("mid_rst_fe", 64'(frame_err), 64'd0);
    model_reset();
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2);
    for (int k = 0; k < 4; k++) bus_bit(1'b0);
    bus_bit(1'b0);
    for (int i = 2; i < N; i++) tx_data(8'($urandom_range(0, 255)), (i == N - 1));
    tx_stop();
    drain();
    chk("t6_dv", 64'(dv_cnt), 64'd1);
    chk("t6_fe", 64'(fe_cnt), 64'd0);
    chk("t6_frame_zero", 64'(frame), 64'd0);
    clr_counts();
    good_burst(1'b1);
    drain();
    chk("t6_next_fd", 64'(fd_cnt), 64'd1);

    // Overflow: one byte past the end, ACKed, then one ignored byte
    clr_counts();
    run_bytes(N + 2, 1'b1);
    drain();
    chk("t7_dv", 64'(dv_cnt), 64'd8);
    chk("t7_fe", 64'(fe_cnt), 64'd1);
    chk("t7_fd", 64'(fd_cnt), 64'd0);

    // Randomised traffic
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 4))
        0: good_burst(1'($urandom_range(0, 1)));
        1: begin
          do a = 8'($urandom_range(0, 255)); while (a == 8'hA1);
          tx_start();
          tx_addr(a, 1'($urandom_range(0, 1)));
          for (int i = 0; i < N; i++) tx_data(8'($urandom_range(0, 255)), (i == N - 1));
          tx_stop();
        end
        2: run_bytes($urandom_range(1, N - 1), 1'b1);
        3: abort_burst($urandom_range(0, N - 1), $urandom_range(0, 8), 1'($urandom_range(0, 1)));
        default: run_bytes(N + 1 + $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      endcase
      drain();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/i2c_read_capture.md
Name: i2c_read_capture

Overview:
- Passive downstream stage of the I2C bus master.
- Monitors the bus SCL/SDA and recognises START, repeated START and STOP.
- Decodes the address byte and deserialises the data bytes the slave returns during the master's read burst.
- Presents each byte as a one-cycle strobe and the complete burst as a held, packed frame for the application logic.

Parameters:
- DEV_ADDR, 7'h50, 7-bit slave address whose read bursts are captured; all other addresses are ignored.
- NBYTES, 7, expected data bytes per read burst (master ACKs NBYTES-1, NACKs the last).
- SYNC_STAGES, 2, flip-flop depth of the SCL and SDA input synchronisers (minimum 2).

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  asynchronous active-low reset.
- scl  in  1  bus clock as driven by the master.
- sda_in  in  1  resolved SDA line level.
- data_out  out  8  last captured data byte, MSB first on bus.
- data_valid  out  1  one-cycle strobe: data_out updated.
- byte_idx  out  $clog2(NBYTES)+1  index of the byte in data_out (0 = first).
- frame  out  8*NBYTES  full burst, byte 0 in [8*NBYTES-1 -: 8]; held until next good burst.
- frame_done  out  1  one-cycle strobe: frame updated.
- frame_err  out  1  one-cycle strobe: burst aborted or malformed.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, frame 0, synchronisers preset to 1 (idle bus), state IDLE, counters 0.
- scl and sda_in pass through SYNC_STAGES flops. Edge detection uses the last two synchronised samples. All decisions use synchronised values only.
- START/repeated START: SDA 1->0 while SCL=1. STOP: SDA 0->1 while SCL=1. Both override every state in the same cycle they are detected.
- Bits are sampled on the synchronised SCL rising edge, MSB first. A 4-bit counter counts 0..8; bit 8 is the ACK slot.
- States:
  - IDLE: wait for START -> ADDR.
  - ADDR: shift 8 bits -> ADDR_ACK.
  - ADDR_ACK: on the 9th rising edge:
    - address == DEV_ADDR, R/W=1, ACK=0 -> DATA.
    - address match with R/W=0 -> WAIT_START (write phase; expect repeated START).
    - address mismatch -> WAIT_START, no error.
    - match with R/W=1 but ACK=1 -> IDLE, frame_err.
  - WAIT_START: ignore bits; START -> ADDR; STOP -> IDLE.
  - DATA: shift 8 bits. On the 8th edge, one clk later: data_out loaded, data_valid=1, byte_idx=count, byte written into the frame shadow register, count++. -> DATA_ACK.
  - DATA_ACK: on the 9th edge:
    - ACK=0 -> DATA.
    - ACK=1 (NACK) with count==NBYTES -> shadow copied to frame, frame_done=1 one clk later -> IDLE.
    - NACK with count!=NBYTES -> frame_err, frame unchanged -> IDLE.
- Overflow: the byte with count==NBYTES that is followed by ACK=0 -> frame_err, -> WAIT_START. Bytes beyond NBYTES are still strobed on data_valid; byte_idx saturates at NBYTES.
- START or STOP in DATA/DATA_ACK before a terminating NACK -> frame_err, partial byte discarded, frame unchanged; START goes to ADDR, STOP goes to IDLE.
- START during ADDR/ADDR_ACK -> restart ADDR with the bit counter cleared, no error.
- STOP in WAIT_START/IDLE: no error.
- data_valid, frame_done and frame_err are never asserted in the same cycle.
- Reset mid-burst: immediate clear. The next burst is accepted only after a fresh START.
- Latency: bus rising edge -> sample = SYNC_STAGES+1 clk; strobe one clk after sample.

Test Plan:
- Master full sequence: write 0xA0, repeated START, read 0xA1, slave returns 11,22,33,44,55,66,77 with NACK on 7th -> seven data_valid strobes with byte_idx 0..6; frame_done once; frame=0x11223344556677; no frame_err.
- Read address 0xA3 (mismatch) followed by 7 bytes -> no data_valid, no frame_done; frame keeps its previous value.
- Read burst with NACK after 4th byte -> 4 data_valid, frame_err once, frame unchanged, next START accepted.
- STOP injected after bit 5 of byte 3 -> frame_err, no data_valid for byte 3, state IDLE; a following good burst yields frame_done.
- Slave NACKs the address (ACK slot =1) -> frame_err, no data strobes.
- rst_n pulsed low mid-byte 2, then released -> all outputs 0 immediately; the bus remainder is ignored until the next START; a subsequent full burst is captured correctly.
